// File: rtl/pool2x2_ctrl.sv
// Streaming 2x2/stride-2 signed int8 max-pool sequencer: buffers one even row, pools on each
// odd-row/odd-column pixel and emits one registered result per window with frame tracking.
module pool2x2_ctrl #(
   parameter int unsigned IMG_W = 24,
   parameter int unsigned IMG_H = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       frame_done,
   output logic       busy
);

   localparam int unsigned ColW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int unsigned RowW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

   if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
      $error("pool2x2_ctrl: IMG_W must be even and >= 2");
   end
   if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
      $error("pool2x2_ctrl: IMG_H must be even and >= 2");
   end

   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic [7:0]      prev_q, prev_d;
   logic            out_valid_q, out_valid_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            out_last_q, out_last_d;
   logic            frame_done_q, frame_done_d;
   logic [7:0]      linebuf_q [IMG_W];

   logic              accept, at_col_end, at_last, window;
   logic signed [7:0] win0, win1, win2, win3, max01, max23, pool_max;

   assign in_ready   = !clear && !(out_valid_q && !out_ready);
   assign accept     = in_valid && in_ready;
   assign at_col_end = (col_q == ColLast);
   assign at_last    = at_col_end && (row_q == RowLast);
   assign window     = accept && row_q[0] && col_q[0];

   // Window is only consumed when col is odd, so col-1 never underflows.
   assign win0     = linebuf_q[col_q - ColW'(1)];
   assign win1     = linebuf_q[col_q];
   assign win2     = prev_q;
   assign win3     = in_data;
   assign max01    = (win0 > win1) ? win0 : win1;
   assign max23    = (win2 > win3) ? win2 : win3;
   assign pool_max = (max01 > max23) ? max01 : max23;

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      prev_d       = prev_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      frame_done_d = 1'b0;
      if (clear) begin
         col_d       = '0;
         row_d       = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_last_d  = 1'b0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
         end
         if (accept) begin
            if (at_col_end) begin
               col_d = '0;
               row_d = at_last ? '0 : row_q + RowW'(1);
            end else begin
               col_d = col_q + ColW'(1);
            end
            if (row_q[0] && !col_q[0]) begin
               prev_d = in_data;
            end
            // A new window result overrides the handshake clear above.
            if (window) begin
               out_valid_d = 1'b1;
               out_data_d  = pool_max;
               out_last_d  = at_last;
            end
            frame_done_d = at_last;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         prev_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         prev_q       <= prev_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !row_q[0]) begin
         linebuf_q[col_q] <= in_data;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;
   assign busy       = (row_q != '0) || (col_q != '0) || out_valid_q;

endmodule
